// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: arbiter state encoding, GMII width and
// default timing constants.
package eth_pkg;

  localparam int GMII_W          = 8;
  localparam int ETH_IFG         = 12;
  localparam int ETH_MAX_LEN     = 1530;
  localparam int ETH_GNT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    IFG   = 2'd3
  } arb_state_t;

  // Two-way round-robin choice: ptr decides only when both sources request.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic ptr);
    return (req0 && req1) ? ptr : req1;
  endfunction

endpackage

// File: rtl/gmii_tx_arb.sv
// Two-source GMII transmit arbiter: whole-frame round-robin grants, registered
// GMII output, inter-frame gap, runaway-frame truncation and grant timeout.
module gmii_tx_arb
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES  = ETH_IFG,
  parameter int MAX_LEN     = ETH_MAX_LEN,
  parameter int GNT_TIMEOUT = ETH_GNT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  output logic              gnt0,
  input  logic              txen0,
  input  logic [GMII_W-1:0] txd0,
  input  logic              req1,
  output logic              gnt1,
  input  logic              txen1,
  input  logic [GMII_W-1:0] txd1,
  output logic              gmii_txen,
  output logic [GMII_W-1:0] gmii_txd,
  output logic              busy,
  output logic              trunc_err,
  output logic              gnt_err
);

  localparam int IFG_W  = $clog2(IFG_CYCLES + 2);
  localparam int LEN_W  = $clog2(MAX_LEN + 2);
  localparam int WAIT_W = $clog2(GNT_TIMEOUT + 2);

  localparam logic [IFG_W-1:0]  IFG_LOAD  = IFG_W'(IFG_CYCLES);
  localparam logic [IFG_W-1:0]  IFG_ONE   = IFG_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNT_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  arb_state_t        state_r, state_nxt_s;
  logic              owner_r, owner_nxt_s;
  logic              ptr_r, ptr_nxt_s;
  logic              gnt0_r, gnt0_nxt_s;
  logic              gnt1_r, gnt1_nxt_s;
  logic              txen_r, txen_nxt_s;
  logic [GMII_W-1:0] txd_r, txd_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              trunc_r, trunc_nxt_s;
  logic              gnterr_r, gnterr_nxt_s;
  logic [WAIT_W-1:0] wait_r, wait_nxt_s;
  logic [LEN_W-1:0]  len_r, len_nxt_s;
  logic [IFG_W-1:0]  ifg_r, ifg_nxt_s;

  logic              pick_s;
  logic              own_req_s;
  logic              own_txen_s;
  logic [GMII_W-1:0] own_txd_s;

  // Only the current owner's lines are ever looked at; the other source is invisible.
  assign pick_s     = rr_pick(req0, req1, ptr_r);
  assign own_req_s  = owner_r ? req1  : req0;
  assign own_txen_s = owner_r ? txen1 : txen0;
  assign own_txd_s  = owner_r ? txd1  : txd0;

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    ptr_nxt_s    = ptr_r;
    gnt0_nxt_s   = gnt0_r;
    gnt1_nxt_s   = gnt1_r;
    txen_nxt_s   = 1'b0;
    txd_nxt_s    = {GMII_W{1'b0}};
    trunc_nxt_s  = 1'b0;
    gnterr_nxt_s = 1'b0;
    wait_nxt_s   = wait_r;
    len_nxt_s    = len_r;
    ifg_nxt_s    = ifg_r;

    case (state_r)
      IDLE: begin
        wait_nxt_s = {WAIT_W{1'b0}};
        len_nxt_s  = {LEN_W{1'b0}};
        if (req0 || req1) begin
          owner_nxt_s = pick_s;
          gnt0_nxt_s  = ~pick_s;
          gnt1_nxt_s  = pick_s;
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      GRANT: begin
        if (own_txen_s) begin
          txen_nxt_s  = 1'b1;
          txd_nxt_s   = own_txd_s;
          len_nxt_s   = LEN_ONE;
          state_nxt_s = SEND;
        end else if (!own_req_s) begin
          gnt0_nxt_s  = 1'b0;
          gnt1_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else if (wait_r >= WAIT_LAST) begin
          // Penalise an idle owner: the other source gets first pick next time.
          gnt0_nxt_s   = 1'b0;
          gnt1_nxt_s   = 1'b0;
          gnterr_nxt_s = 1'b1;
          ptr_nxt_s    = ~owner_r;
          state_nxt_s  = IDLE;
        end else begin
          wait_nxt_s = wait_r + WAIT_ONE;
        end
      end

      SEND: begin
        if (own_txen_s && (len_r < LEN_MAX)) begin
          txen_nxt_s = 1'b1;
          txd_nxt_s  = own_txd_s;
          len_nxt_s  = len_r + LEN_ONE;
        end else begin
          // Frame end or runaway cut; both close the frame and start the gap.
          trunc_nxt_s = own_txen_s;
          gnt0_nxt_s  = 1'b0;
          gnt1_nxt_s  = 1'b0;
          ptr_nxt_s   = ~owner_r;
          ifg_nxt_s   = IFG_LOAD;
          state_nxt_s = IFG;
        end
      end

      IFG: begin
        if (ifg_r <= IFG_ONE) begin
          ifg_nxt_s   = {IFG_W{1'b0}};
          state_nxt_s = IDLE;
        end else begin
          ifg_nxt_s = ifg_r - IFG_ONE;
        end
      end

      default: begin
        gnt0_nxt_s  = 1'b0;
        gnt1_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, counters and all outputs registered; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      ptr_r    <= 1'b0;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      txen_r   <= 1'b0;
      txd_r    <= {GMII_W{1'b0}};
      busy_r   <= 1'b0;
      trunc_r  <= 1'b0;
      gnterr_r <= 1'b0;
      wait_r   <= {WAIT_W{1'b0}};
      len_r    <= {LEN_W{1'b0}};
      ifg_r    <= {IFG_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      ptr_r    <= ptr_nxt_s;
      gnt0_r   <= gnt0_nxt_s;
      gnt1_r   <= gnt1_nxt_s;
      txen_r   <= txen_nxt_s;
      txd_r    <= txd_nxt_s;
      busy_r   <= busy_nxt_s;
      trunc_r  <= trunc_nxt_s;
      gnterr_r <= gnterr_nxt_s;
      wait_r   <= wait_nxt_s;
      len_r    <= len_nxt_s;
      ifg_r    <= ifg_nxt_s;
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign gmii_txen = txen_r;
  assign gmii_txd  = txd_r;
  assign busy      = busy_r;
  assign trunc_err = trunc_r;
  assign gnt_err   = gnterr_r;

endmodule

// File: tb/tb_gmii_tx_arb.sv
// Scoreboard bench for gmii_tx_arb: source drivers push expected output frames
// when granted; an independent monitor pops and compares every GMII frame.
module tb_gmii_tx_arb;

  localparam int IFG  = 12;
  localparam int MAXL = 1530;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_v, txen_v;
  logic [1:0][7:0] txd_v;
  logic            gnt0, gnt1, gmii_txen, busy, trunc_err, gnt_err;
  logic [7:0]      gmii_txd;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit abort = 1'b0;

  logic [7:0] exp_data[$];
  int         exp_len[$];
  logic [7:0] cur[$];
  int gnt_order[$];
  int gnt_rise_cyc[2], gnt_fall_cyc[2];
  int out_rise_cyc, out_fall_cyc, busy_fall_cyc, in_rise_cyc, in_fall_cyc, req_cyc;
  int trunc_cnt = 0, gnterr_cnt = 0, mutex_viol = 0, idle_data_viol = 0, longest = 0;

  gmii_tx_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req_v[0]), .gnt0(gnt0), .txen0(txen_v[0]), .txd0(txd_v[0]),
    .req1(req_v[1]), .gnt1(gnt1), .txen1(txen_v[1]), .txd1(txd_v[1]),
    .gmii_txen(gmii_txen), .gmii_txd(gmii_txd), .busy(busy),
    .trunc_err(trunc_err), .gnt_err(gnt_err)
  );

  always #4 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #640000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic gnt_of(input int s);
    return (s == 1) ? gnt1 : gnt0;
  endfunction

  function automatic int order_code(input int n);
    int code = 0;
    for (int i = 0; i < n; i++) code = code * 10 + ((i < gnt_order.size()) ? gnt_order[i] : 9);
    return code;
  endfunction

  task automatic release_src(input int s);
    req_v[s]  = 1'b0;
    txen_v[s] = 1'b0;
    txd_v[s]  = 8'h00;
  endtask

  // One frame from source s: request, wait for grant, send n bytes, release.
  task automatic src_frame(input int s, input int n, input bit preamble, input bit timing);
    logic [7:0] b[$];
    int w, l;
    for (int i = 0; i < n; i++)
      b.push_back(preamble ? ((i == n - 1) ? 8'hD5 : 8'h55) : 8'($urandom_range(255)));
    @(negedge clk);
    req_v[s] = 1'b1;
    req_cyc  = cyc;
    w = 0;
    do begin @(negedge clk); w++; end while (!gnt_of(s) && !abort && w < 6000);
    if (abort) begin release_src(s); return; end
    check($sformatf("gnt_wait_src%0d", s), int'(gnt_of(s)), 1);
    if (!gnt_of(s)) begin release_src(s); return; end
    if (timing) check("gnt_latency", gnt_rise_cyc[s] - req_cyc, 1);
    l = (n > MAXL) ? MAXL : n;
    exp_len.push_back(l);
    for (int i = 0; i < l; i++) exp_data.push_back(b[i]);
    in_rise_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      txen_v[s] = 1'b1;
      txd_v[s]  = b[i];
      @(negedge clk);
      if (abort) begin release_src(s); return; end
      if (!gnt_of(s)) req_v[s] = 1'b0;
    end
    release_src(s);
    in_fall_cyc = cyc;
    w = 0;
    while (gnt_of(s) && w < 50) begin @(negedge clk); w++; end
    check($sformatf("gnt_release_src%0d", s), int'(gnt_of(s)), 0);
    if (timing) check("gnt_fall_after_txen", gnt_fall_cyc[s] - in_fall_cyc, 1);
  endtask

  // Source s requests but never transmits; gives up once the grant is revoked.
  task automatic lazy_src(input int s);
    int w;
    @(negedge clk);
    req_v[s] = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!gnt_of(s) && w < 200);
    w = 0;
    while (gnt_of(s) && w < 100) begin @(negedge clk); w++; end
    check("lazy_gnt_revoked", int'(gnt_of(s)), 0);
    req_v[s] = 1'b0;
  endtask

  task automatic noise1(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txen_v[1] = 1'($urandom_range(1));
      txd_v[1]  = 8'($urandom_range(255));
    end
    txen_v[1] = 1'b0;
    txd_v[1]  = 8'h00;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 300) begin @(negedge clk); w++; end
    check("wait_idle", int'(busy), 0);
  endtask

  // Monitor: collects GMII frames and compares each against the scoreboard.
  initial begin
    logic       prev_txen = 1'b0, prev_busy = 1'b0;
    logic [1:0] prev_gnt = 2'b00, g;
    bit         seen = 1'b0;
    int         gap = 0, l, bad;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur.delete();
        prev_txen = 1'b0; prev_busy = 1'b0; prev_gnt = 2'b00; seen = 1'b0; gap = 0;
      end else begin
        if (gnt0 && gnt1) mutex_viol++;
        if (!gmii_txen && gmii_txd != 8'h00) idle_data_viol++;
        if (trunc_err) trunc_cnt++;
        if (gnt_err) gnterr_cnt++;
        g = {gnt1, gnt0};
        for (int s = 0; s < 2; s++) begin
          if (g[s] && !prev_gnt[s]) begin gnt_rise_cyc[s] = cyc; gnt_order.push_back(s); end
          if (!g[s] && prev_gnt[s]) gnt_fall_cyc[s] = cyc;
        end
        if (!busy && prev_busy) busy_fall_cyc = cyc;
        if (gmii_txen) begin
          if (!prev_txen) begin
            out_rise_cyc = cyc;
            if (seen) begin
              n_tests++;
              if (gap < IFG) begin
                n_fail++;
                $display("FAIL ifg_gap: got %0d idle cycles expected at least %0d", gap, IFG);
              end
            end
          end
          cur.push_back(gmii_txd);
        end else if (prev_txen) begin
          out_fall_cyc = cyc;
          if (cur.size() > longest) longest = cur.size();
          n_tests++;
          if (exp_len.size() == 0) begin
            n_fail++;
            $display("FAIL frame: got unexpected frame of %0d bytes expected none", cur.size());
          end else begin
            l = exp_len.pop_front();
            bad = -1;
            for (int i = 0; i < l; i++) begin
              e = exp_data.pop_front();
              if (bad < 0 && (i >= cur.size() || cur[i] != e)) bad = i;
            end
            if (cur.size() != l || bad >= 0) begin
              n_fail++;
              $display("FAIL frame: got %0d bytes expected %0d bytes, first bad byte index %0d",
                       cur.size(), l, bad);
            end
          end
          cur.delete();
          seen = 1'b1;
          gap  = 1;
        end else begin
          gap++;
        end
        prev_txen = gmii_txen;
        prev_busy = busy;
        prev_gnt  = g;
      end
    end
  end

  initial begin
    int t0, w;
    rst_n = 1'b0; req_v = 2'b00; txen_v = 2'b00; txd_v = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", int'({gnt0, gnt1, gmii_txen, gmii_txd, busy, trunc_err, gnt_err}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests with re-requests: strict alternation from source 0.
    gnt_order.delete();
    fork
      begin src_frame(0, 60, 1'b0, 1'b0); src_frame(0, 60, 1'b0, 1'b0); end
      begin src_frame(1, 60, 1'b0, 1'b0); src_frame(1, 60, 1'b0, 1'b0); end
    join
    check("rr_order_0101", order_code(4), 101);
    wait_idle();

    // Single source, preamble pattern, exact latencies and gap length.
    src_frame(0, 64, 1'b1, 1'b1);
    check("txen_delay", out_rise_cyc - in_rise_cyc, 1);
    wait_idle();
    check("ifg_len", busy_fall_cyc - out_fall_cyc, IFG);

    // Foreign txen1 activity while source 0 owns the path.
    fork
      src_frame(0, 80, 1'b0, 1'b0);
      noise1(200);
    join
    wait_idle();

    // Runaway source 1 is cut at MAX_LEN; waiting source 0 is served next.
    t0 = trunc_cnt;
    gnt_order.delete();
    fork
      src_frame(1, 2000, 1'b0, 1'b0);
      begin repeat (100) @(negedge clk); src_frame(0, 50, 1'b0, 1'b0); end
    join
    check("trunc_pulses", trunc_cnt - t0, 1);
    check("trunc_len", longest, MAXL);
    check("after_trunc_order", order_code(2), 10);
    wait_idle();

    // Source 0 never transmits: grant revoked, source 1 served without gap.
    t0 = gnterr_cnt;
    gnt_order.delete();
    fork
      lazy_src(0);
      begin repeat (4) @(negedge clk); src_frame(1, 30, 1'b0, 1'b0); end
    join
    check("gnt_err_pulses", gnterr_cnt - t0, 1);
    check("gnt_hold", gnt_fall_cyc[0] - gnt_rise_cyc[0], TMO);
    check("gnt1_after_timeout", gnt_rise_cyc[1] - gnt_fall_cyc[0], 1);
    check("timeout_order", order_code(2), 1);
    wait_idle();

    // Random contention.
    for (int r = 0; r < 3; r++) begin
      fork
        for (int k = 0; k < 4; k++) begin
          repeat ($urandom_range(30)) @(negedge clk);
          src_frame(0, $urandom_range(1, 120), 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
          repeat ($urandom_range(30)) @(negedge clk);
          src_frame(1, $urandom_range(1, 120), 1'b0, 1'b0);
        end
      join
      wait_idle();
    end

    // Asynchronous reset in the middle of a frame, then a clean frame.
    fork
      src_frame(0, 100, 1'b0, 1'b0);
    join_none
    w = 0;
    while (cur.size() < 30 && w < 500) begin @(negedge clk); w++; end
    check("reach_byte30", int'(cur.size() >= 30), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_txen", int'(gmii_txen), 0);
    check("async_rst_gnt0", int'(gnt0), 0);
    check("async_rst_busy", int'(busy), 0);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    exp_data.delete();
    exp_len.delete();
    @(negedge clk);
    rst_n = 1'b1;
    src_frame(0, 40, 1'b0, 1'b0);
    wait_idle();

    check("scoreboard_empty", exp_len.size(), 0);
    check("gnt_mutex_violations", mutex_viol, 0);
    check("idle_txd_violations", idle_data_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_tx_arb.md
Name: gmii_tx_arb

Overview:
- Shares the single GMII transmit path (gmii_txen/gmii_txd into the GMII-to-RGMII converter) between two frame sources, e.g. the UDP sender and the ARP/ICMP responder.
- Grants the path round-robin, one whole frame at a time.
- Registers the selected source onto the GMII bus and enforces the Ethernet inter-frame gap.
- Truncates runaway frames and revokes grants that are never used.

Parameters:
- IFG_CYCLES, 12, idle cycles forced on gmii_txen after every frame end (truncated frames included).
- MAX_LEN, 1530, maximum txen-high cycles per frame (preamble+SFD+frame) before forced truncation.
- GNT_TIMEOUT, 16, cycles a granted source may hold the grant without raising txen.

Ports:
- clk  input  1  GMII transmit clock (125 MHz, same net as gmii_txc).
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  source 0 requests the path; held high until its frame has been sent.
- gnt0  output  1  source 0 owns the path.
- txen0  input  1  source 0 frame valid; ignored while gnt0 is low.
- txd0  input  8  source 0 frame byte.
- req1  input  1  source 1 request.
- gnt1  output  1  source 1 grant.
- txen1  input  1  source 1 frame valid.
- txd1  input  8  source 1 byte.
- gmii_txen  output  1  registered transmit enable to the converter.
- gmii_txd  output  8  registered transmit data; 8'h00 whenever gmii_txen is low.
- busy  output  1  state is not IDLE.
- trunc_err  output  1  one-cycle pulse when a frame is cut at MAX_LEN.
- gnt_err  output  1  one-cycle pulse when a grant times out.

Behaviour:
- Reset: the async assert of rst_n clears everything immediately.
  - State IDLE; gnt0, gnt1, gmii_txen, busy, trunc_err and gnt_err all 0; gmii_txd 8'h00.
  - Round-robin pointer = 0 (source 0 has priority first); all counters 0.
  - Release of rst_n is synchronised by the top-level reset synchroniser.
- State IDLE:
  - If only one req is high, grant it. If both are high, grant the source the pointer selects.
  - The gnt register rises on the next edge and the state moves to GRANT.
  - At most one gnt is high at any time.
- State GRANT:
  - Wait counter increments each cycle.
  - If txen of the owner is high, move to SEND; that first byte already appears on gmii_txd one cycle later.
  - If the owner's req falls before any txen: drop gnt, return to IDLE, no IFG, pointer unchanged.
  - If the counter reaches GNT_TIMEOUT: drop gnt, pulse gnt_err, return to IDLE, pointer toggles away from the offender.
- State SEND:
  - gmii_txen and gmii_txd are the owner's txen/txd delayed exactly 1 cycle.
  - The length counter increments per txen-high cycle.
  - When the owner's txen is sampled low, the frame ends:
    - gmii_txen goes low on the next edge and gnt drops on the same edge.
    - Pointer toggles to the other source; IFG counter loads IFG_CYCLES; move to IFG.
  - When the length count reaches MAX_LEN with txen still high:
    - gmii_txen is forced low on the next edge; trunc_err pulses; gnt drops.
    - Pointer toggles; move to IFG.
    - The source's remaining bytes are discarded because gnt is low.
- State IFG:
  - gmii_txen is held low for exactly IFG_CYCLES cycles, then the state returns to IDLE.
  - Requests arriving during IFG wait. A grant may be issued on the IDLE cycle after IFG (first gnt edge IFG_CYCLES+1 cycles after gmii_txen fell).
- The non-owner's txen and txd never reach the output. A txen that is high without a grant is ignored silently.
- Counters are sized by $clog2 of their parameter and saturate; they never wrap.
- A simultaneous req drop and txen rise while in GRANT: txen wins and the state moves to SEND.

Decomposition:
- Shared package eth_pkg holds:
  - the state enum: IDLE, GRANT, SEND, IFG (2 bits);
  - default constants ETH_IFG=12 and ETH_MAX_LEN=1530;
  - GMII byte width 8.
- No sub-module is needed. The 2-way round-robin pointer and the output mux stay inline.

Test Plan:
1. Only req0 high, source sends 64 txen cycles of 8'h55 then 8'hD5: gnt0 rises 1 cycle after req0; gmii_txen shows the identical 64-cycle pattern delayed 1; after the frame, gmii_txen stays low 12 cycles; gnt0 falls 1 cycle after txen0 falls.
2. req0 and req1 raised on the same edge, each sends 60 bytes, and both re-request:
   - required order is source 0, 1, 0, 1;
   - consecutive output frames are separated by ≥12 idle cycles;
   - gnt0 and gnt1 are never high together.
3. Source 1 holds txen1 high for 2000 cycles: gmii_txen is high for exactly 1530 cycles; trunc_err pulses once; gnt1 drops; the next grant goes to source 0 if it is requesting.
4. Source 0 receives its grant and never raises txen0: gnt0 drops after 16 cycles; gnt_err pulses; if req1 is pending, gnt1 rises with no IFG.
5. rst_n pulled low in the middle of SEND (byte 30): gmii_txen, gnt0 and busy go low asynchronously; after release, a new req0 frame transmits normally.
6. txen1 toggled while source 0 owns the path: gmii_txd and gmii_txen carry only source 0 data.
